// File: rtl/morse_pkg.sv
// Shared types and Morse timing constants for the encoder.
// Optional macro MORSE_ENC_WORD_GAP_EN adds the WORD_GAP state.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SPACE,
`ifdef MORSE_ENC_WORD_GAP_EN
    CHAR_GAP,
    WORD_GAP
`else
    CHAR_GAP
`endif
  } morse_enc_state_t;

  localparam int MORSE_MAX_ELEMS      = 6;
  localparam int DOT_UNITS            = 1;
  localparam int DASH_UNITS           = 3;
  localparam int ELEM_GAP_UNITS       = 1;
  localparam int CHAR_GAP_UNITS       = 3;
  localparam int WORD_GAP_EXTRA_UNITS = 4;

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter measuring whole Morse units of DOT_CLKS cycles.
// Ports: clk, reset (async high), i_load, i_units, i_trim, o_expire.
module morse_unit_timer #(
  parameter int DOT_CLKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [2:0] i_units,
  input  logic       i_trim,
  output logic       o_expire
);

  localparam int CNT_W = $clog2(7 * DOT_CLKS + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_load_val;

  // The state runs for (load value + 1) cycles; i_trim gives one
  // cycle back to the following IDLE cycle.
  always_comb begin
    w_load_val = CNT_W'(int'(i_units) * DOT_CLKS - 1 - int'(i_trim));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/morse_encoder.sv
// Serialises one Morse character per valid/ready handshake onto key_o.
// Ports: clk, reset (async high), char_valid_i, char_len_i, char_pat_i,
//        char_ready_o, key_o, busy_o, done_o.
// Optional macro MORSE_ENC_WORD_GAP_EN: len==0 sends a 4-unit word gap.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int DOT_CLKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid_i,
  input  logic [2:0] char_len_i,
  input  logic [5:0] char_pat_i,
  output logic       char_ready_o,
  output logic       key_o,
  output logic       busy_o,
  output logic       done_o
);

  morse_enc_state_t r_state;
  logic [2:0]       r_len;
  logic [5:0]       r_pat;
  logic [2:0]       r_idx;

  logic       w_xfer;
  logic [2:0] w_len_in;
  logic       w_last;
  logic       w_load;
  logic [2:0] w_units;
  logic       w_trim;
  logic       w_expire;

  morse_unit_timer #(
    .DOT_CLKS (DOT_CLKS)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_units  (w_units),
    .i_trim   (w_trim),
    .o_expire (w_expire)
  );

  assign char_ready_o = (r_state == IDLE);
  assign busy_o       = (r_state != IDLE);
  assign w_xfer       = char_valid_i && (r_state == IDLE);
  assign w_len_in     = (char_len_i == 3'd7) ? 3'(MORSE_MAX_ELEMS)
                                             : char_len_i;
  assign w_last       = (r_idx == r_len - 3'd1);

  // Gaps that end in IDLE are one cycle short: the IDLE/done cycle is
  // itself key-low, so back-to-back characters get exactly 3 units.
  always_comb begin
    w_load  = 1'b0;
    w_units = '0;
    w_trim  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer && w_len_in != 3'd0) begin
          w_load  = 1'b1;
          w_units = char_pat_i[0] ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
        end
`ifdef MORSE_ENC_WORD_GAP_EN
        else if (w_xfer) begin
          w_load  = 1'b1;
          w_units = 3'(WORD_GAP_EXTRA_UNITS);
          w_trim  = 1'b1;
        end
`endif
      end
      MARK: begin
        if (w_expire) begin
          w_load = 1'b1;
          if (w_last) begin
            w_units = 3'(CHAR_GAP_UNITS);
            w_trim  = 1'b1;
          end else begin
            w_units = 3'(ELEM_GAP_UNITS);
          end
        end
      end
      SPACE: begin
        if (w_expire) begin
          w_load  = 1'b1;
          w_units = r_pat[r_idx] ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_pat   <= '0;
      r_idx   <= '0;
      key_o   <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (w_len_in != 3'd0) begin
              r_len   <= w_len_in;
              r_pat   <= char_pat_i;
              r_idx   <= '0;
              key_o   <= 1'b1;
              r_state <= MARK;
            end else begin
`ifdef MORSE_ENC_WORD_GAP_EN
              r_state <= WORD_GAP;
`else
              done_o  <= 1'b1;
`endif
            end
          end
        end
        MARK: begin
          if (w_expire) begin
            key_o <= 1'b0;
            if (w_last) begin
              r_state <= CHAR_GAP;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= SPACE;
            end
          end
        end
        SPACE: begin
          if (w_expire) begin
            key_o   <= 1'b1;
            r_state <= MARK;
          end
        end
        CHAR_GAP: begin
          if (w_expire) begin
            done_o  <= 1'b1;
            r_state <= IDLE;
          end
        end
`ifdef MORSE_ENC_WORD_GAP_EN
        WORD_GAP: begin
          if (w_expire) begin
            done_o  <= 1'b1;
            r_state <= IDLE;
          end
        end
`endif
        default: begin
          key_o   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Randomised and directed bench for morse_encoder (DOT_CLKS=4),
// checked every cycle against a per-cycle key waveform model.
module tb_morse_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       char_valid_i;
  logic [2:0] char_len_i;
  logic [5:0] char_pat_i;
  logic       char_ready_o;
  logic       key_o;
  logic       busy_o;
  logic       done_o;

  morse_encoder #(.DOT_CLKS(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .char_valid_i (char_valid_i),
    .char_len_i   (char_len_i),
    .char_pat_i   (char_pat_i),
    .char_ready_o (char_ready_o),
    .key_o        (key_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: one entry per busy cycle holding the expected key level.
  bit q[$];
  bit exp_done = 1'b0;

  // Run-length observations of the DUT key line.
  bit prev_key = 1'b0;
  bit seen_high = 1'b0;
  int run = 0;
  int last_high = 0;
  int last_gap = 0;
  int n_high = 0;
  int n_dash = 0;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit rdy;
    bit nd;
    int n;
    rdy = (q.size() == 0);
    nd  = 1'b0;
    if (!rdy) begin
      void'(q.pop_front());
      if (q.size() == 0) nd = 1'b1;
    end
    if (rdy && char_valid_i && !reset) begin
      n = (char_len_i == 3'd7) ? 6 : int'(char_len_i);
      if (n == 0) begin
`ifdef MORSE_ENC_WORD_GAP_EN
        repeat (4 * D - 1) q.push_back(1'b0);
`else
        nd = 1'b1;
`endif
      end else begin
        for (int e = 0; e < n; e++) begin
          repeat ((char_pat_i[e] ? 3 : 1) * D) q.push_back(1'b1);
          if (e < n - 1) repeat (D) q.push_back(1'b0);
          else repeat (3 * D - 1) q.push_back(1'b0);
        end
      end
    end
    exp_done = nd;
  endtask

  task automatic check_cycle();
    bit ek;
    ek = (q.size() != 0) ? q[0] : 1'b0;
    chk("key_o", int'(key_o), int'(ek));
    chk("busy_o", int'(busy_o), int'(q.size() != 0));
    chk("char_ready_o", int'(char_ready_o), int'(q.size() == 0));
    chk("done_o", int'(done_o), int'(exp_done));
    chk("busy_ready_excl", int'(busy_o & char_ready_o), 0);
    if (key_o !== prev_key) begin
      if (key_o) begin
        if (seen_high) last_gap = run;
      end else begin
        last_high = run;
        n_high++;
        if (run == 3 * D) n_dash++;
        seen_high = 1'b1;
      end
      run = 1;
    end else begin
      run++;
    end
    prev_key = key_o;
  endtask

  task automatic step(input bit v, input logic [2:0] l,
                      input logic [5:0] p);
    char_valid_i = v;
    char_len_i   = l;
    char_pat_i   = p;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  // Run with valid low until the model is idle (ends in the done cycle).
  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 400) begin
      step(1'b0, 3'd0, 6'd0);
      guard++;
    end
    chk("drain_timeout", int'(q.size() != 0), 0);
  endtask

  int h0;
  int d0;

  initial begin
    reset = 1'b1;
    char_valid_i = 1'b0;
    char_len_i = '0;
    char_pat_i = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", int'(char_ready_o), 1);
    chk("rst_key", int'(key_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    step(1'b0, 3'd0, 6'd0);

    // 'E'
    step(1'b1, 3'd1, 6'd0);
    chk("E_model_len", q.size(), 15);
    drain();
    chk("E_done", int'(done_o), 1);
    chk("E_high", last_high, 4);
    step(1'b0, 3'd0, 6'd0);

    // 'A'
    h0 = n_high;
    step(1'b1, 3'd2, 6'b000010);
    chk("A_model_len", q.size(), 31);
    drain();
    chk("A_marks", n_high - h0, 2);
    chk("A_dash", last_high, 12);
    chk("A_gap", last_gap, 4);
    step(1'b0, 3'd0, 6'd0);

    // Back-to-back 'T','T' with valid held
    step(1'b1, 3'd1, 6'd1);
    while (q.size() != 0) step(1'b1, 3'd1, 6'd1);
    chk("TT_done", int'(done_o), 1);
    step(1'b1, 3'd1, 6'd1);
    chk("TT_second_xfer", int'(busy_o), 1);
    drain();
    chk("TT_gap", last_gap, 12);
    step(1'b0, 3'd0, 6'd0);

    // len=7 clamps to six dashes
    h0 = n_high;
    d0 = n_dash;
    step(1'b1, 3'd7, 6'b111111);
    chk("L7_model_len", q.size(), 103);
    drain();
    chk("L7_marks", n_high - h0, 6);
    chk("L7_dashes", n_dash - d0, 6);
    step(1'b0, 3'd0, 6'd0);

    // Reset in cycle 6 of a dash
    step(1'b1, 3'd1, 6'd1);
    repeat (5) step(1'b0, 3'd0, 6'd0);
    chk("pre_rst_key", int'(key_o), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_key", int'(key_o), 0);
    chk("arst_ready", int'(char_ready_o), 1);
    q.delete();
    exp_done = 1'b0;
    step(1'b0, 3'd0, 6'd0);
    step(1'b0, 3'd0, 6'd0);
    reset = 1'b0;
    step(1'b0, 3'd0, 6'd0);
    step(1'b1, 3'd1, 6'd0);
    drain();
    chk("post_rst_E", last_high, 4);
    step(1'b0, 3'd0, 6'd0);

    // len=0
    step(1'b1, 3'd0, 6'b101010);
`ifdef MORSE_ENC_WORD_GAP_EN
    chk("L0_model_len", q.size(), 15);
    drain();
    chk("L0_done", int'(done_o), 1);
`else
    chk("L0_done", int'(done_o), 1);
    chk("L0_key", int'(key_o), 0);
`endif
    step(1'b0, 3'd0, 6'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7)),
           6'($urandom));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
